// File: rtl/clarvi_mem_arbiter.sv
// Two-requester arbiter for the Clarvi memory port.
// Fetch and data commands share one pipelined port; responses return in issue order.
module clarvi_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   instr_address,
    input  logic                    instr_read_enable,
    output logic                    instr_wait,
    output logic [DATA_WIDTH-1:0]   instr_read_data,
    output logic                    instr_read_data_valid,
    input  logic [ADDR_WIDTH-1:0]   main_address,
    input  logic [DATA_WIDTH/8-1:0] main_byte_enable,
    input  logic                    main_read_enable,
    input  logic                    main_write_enable,
    input  logic [DATA_WIDTH-1:0]   main_write_data,
    output logic                    main_wait,
    output logic [DATA_WIDTH-1:0]   main_read_data,
    output logic                    main_read_data_valid,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    mem_wait,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_read_data_valid,
    output logic                    protocol_error
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_M} state_t;

    state_t state, state_next;

    logic [MAX_PENDING-1:0] src_id;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve;

    logic instr_req, main_req, main_is_read;
    logic full, starved, instr_ok, main_ok;
    logic grant_i, grant_m, push, pop, stray;

    assign instr_req    = instr_read_enable;
    assign main_req     = main_read_enable | main_write_enable;
    assign main_is_read = main_read_enable;
    assign full         = (count == CW'(MAX_PENDING));
    assign starved      = (starve == SW'(STARVE_LIMIT));
    assign instr_ok     = instr_req & ~full;
    assign main_ok      = main_req & (~main_is_read | ~full);

    always_comb begin
        grant_i    = 1'b0;
        grant_m    = 1'b0;
        state_next = state;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (starved && instr_ok)
                        grant_i = 1'b1;
                    else if (main_ok)
                        grant_m = 1'b1;
                    else if (instr_ok)
                        grant_i = 1'b1;
                end
                HOLD_I:  grant_i = 1'b1;
                HOLD_M:  grant_m = 1'b1;
                default: ;
            endcase
        end
        unique case (state)
            IDLE: begin
                if (grant_i && mem_wait)
                    state_next = HOLD_I;
                else if (grant_m && mem_wait)
                    state_next = HOLD_M;
            end
            HOLD_I, HOLD_M: begin
                if (!mem_wait)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_read  = (grant_i & instr_req) | (grant_m & main_is_read);
    assign mem_write = grant_m & main_write_enable & ~main_read_enable;

    assign mem_address = grant_m ? main_address
                       : grant_i ? instr_address : '0;
    assign mem_byte_enable = mem_write ? main_byte_enable
                           : mem_read ? '1 : '0;
    assign mem_write_data = mem_write ? main_write_data : '0;

    assign instr_wait = instr_req & ~(grant_i & ~mem_wait);
    assign main_wait  = main_req & ~(grant_m & ~mem_wait);

    assign push  = mem_read & ~mem_wait;
    assign pop   = mem_read_data_valid & (count != '0) & ~reset;
    assign stray = mem_read_data_valid & (count == '0);

    assign instr_read_data       = mem_read_data;
    assign main_read_data        = mem_read_data;
    assign instr_read_data_valid = pop & ~src_id[rd_ptr];
    assign main_read_data_valid  = pop & src_id[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            src_id         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            starve         <= '0;
            protocol_error <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                src_id[wr_ptr] <= grant_m;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            // Fetch acceptance or withdrawal resets the fairness window.
            if (!instr_req || (grant_i && !mem_wait))
                starve <= '0;
            else if (!starved)
                starve <= starve + SW'(1);
            if (stray)
                protocol_error <= 1'b1;
        end
    end

endmodule

// File: doc/clarvi_mem_arbiter.md
Name: clarvi_mem_arbiter

Overview:
Shares a single pipelined Avalon-MM style memory port between two requesters. The requesters are the instruction-fetch port (read-only) and the main data port (load/store) of the Clarvi pipeline. The block produces the instr_wait and main_wait signals that the decode stage uses to build its memory-stall condition. It tracks outstanding reads in source order and routes each read response back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, byte address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_PENDING, 4, maximum outstanding reads (depth of source-ID FIFO, power of 2, >=2)
STARVE_LIMIT, 8, consecutive denied cycles after which instruction fetch wins arbitration

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_address  in  ADDR_WIDTH  fetch address
instr_read_enable  in  1  fetch read request
instr_wait  out  1  fetch command not accepted this cycle
instr_read_data  out  DATA_WIDTH  fetch read data
instr_read_data_valid  out  1  fetch read data valid
main_address  in  ADDR_WIDTH  data address
main_byte_enable  in  DATA_WIDTH/8  write byte lanes
main_read_enable  in  1  data read request
main_write_enable  in  1  data write request
main_write_data  in  DATA_WIDTH  store data
main_wait  out  1  data command not accepted this cycle
main_read_data  out  DATA_WIDTH  load data
main_read_data_valid  out  1  load data valid
mem_address  out  ADDR_WIDTH  downstream address
mem_byte_enable  out  DATA_WIDTH/8  downstream byte enables (all ones for reads)
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_write_data  out  DATA_WIDTH  downstream write data
mem_wait  in  1  downstream waitrequest
mem_read_data  in  DATA_WIDTH  downstream read data
mem_read_data_valid  in  1  downstream read response
protocol_error  out  1  sticky: response arrived with no outstanding read

Behaviour:
- Request validity: instr_req = instr_read_enable. main_req = main_read_enable | main_write_enable. Read and write both high on the main port is illegal; read takes precedence.
- Grant state is a registered FSM with states IDLE, HOLD_I and HOLD_M.
  - In IDLE, the arbiter picks a source combinationally in the same cycle (zero-latency issue).
    - Priority goes to main.
    - Instr wins if the starve counter equals STARVE_LIMIT.
    - A read from either source is eligible only if the FIFO is not full. Writes are always eligible.
  - If the chosen command sees mem_wait=1, the FSM moves to HOLD_x. It stays there, driving that source's command, until mem_wait=0. The requester must hold its command stable meanwhile. No re-arbitration occurs while holding.
  - When a command is accepted (mem_read|mem_write high and mem_wait=0), the FSM returns to IDLE.
- Wait outputs:
  - x_wait = x_req & !(granted_x & !mem_wait).
  - Both wait outputs are 0 when the matching request is low.
- Downstream outputs: a mux of the granted source. When nothing is granted: mem_read=mem_write=0 and the address/data outputs are don't-care.
- FIFO:
  - Each accepted read pushes a source ID (0=instr, 1=main).
  - Each mem_read_data_valid pops the head and asserts the matching x_read_data_valid in the same cycle. x_read_data = mem_read_data, combinational.
  - Push and pop in the same cycle keep the count unchanged. This is allowed when full: the pop frees the slot. Issue eligibility, however, uses the registered full flag, so a full FIFO blocks reads that cycle even if a pop occurs.
  - Pointers wrap modulo MAX_PENDING. The count ranges 0..MAX_PENDING.
- Starve counter:
  - Increments while instr_req=1 and instr is not accepted, saturating at STARVE_LIMIT.
  - Clears on instr acceptance or when instr_req=0.
- Response with an empty FIFO: the response is dropped, protocol_error is set to 1, and it stays set until reset.
- Reset:
  - State goes to IDLE; FIFO empty; starve counter 0; protocol_error 0.
  - All outputs go to 0, except the wait outputs, which follow their combinational definition.
  - A reset mid-transaction drops all pending responses. Responses arriving afterwards set protocol_error, and the bench must account for this.
- Ordering: responses are assumed in-order from downstream. There are no tags on the bus.

Test Plan:
- Both ports request reads at the same time, mem_wait=0 → cycle 0 main issued, instr_wait=1. Cycle 1 instr issued. Responses D0 then D1 route to main, then instr, each with only one valid high.
- Main write (be=4'b0011), mem_wait=1 for 3 cycles while instr requests → mem_write is held stable with main's address for 4 cycles and instr_wait=1 throughout. Instr issues in the cycle after acceptance.
- MAX_PENDING=4: issue 4 instr reads with no responses → 5th read sees instr_wait=1. A main write is still accepted. After 1 response, the read issues on the following cycle.
- Main requests continuously and instr requests continuously, STARVE_LIMIT=8 → instr is accepted on the 9th cycle, then the counter clears.
- mem_read_data_valid pulsed with the FIFO empty → no x_read_data_valid, protocol_error=1, and it stays 1 until reset.
- Reset asserted with 2 reads outstanding and grant in HOLD_M → the next cycle is IDLE with count 0. A fresh instr read issues immediately after reset deasserts.
